qpu_meas_collect: RTL and testbench



---
 rtl/qpu_meas_collect_pkg.sv | 29 ++
 rtl/qpu_meas_tmo_cnt.sv | 37 +++
 rtl/qpu_meas_collect.sv | 171 +++++++++++++++++
 tb/tb_qpu_meas_collect.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qpu_meas_collect_pkg.sv
// -----------------------------------------------------------------------------
// qpu_meas_collect_pkg
// Shared definitions for the measurement-result collector and the register
// file it feeds: qubit count, readout index width, FSM state encoding and a
// helper that turns a readout index into a qubit bitmap.
// -----------------------------------------------------------------------------
package qpu_meas_collect_pkg;

  localparam int QUBIT_NUM = 12;
  localparam int QIDX_W    = 4;

  typedef logic [QUBIT_NUM-1:0] qmask_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_COMMIT  = 2'd2
  } meas_state_e;

  // One-hot bitmap for a readout index; an index beyond the last physical
  // qubit maps to an empty mask so it can never match a pending qubit.
  function automatic qmask_t qidx_onehot(input logic [QIDX_W-1:0] idx);
    qmask_t m;
    m = '0;
    if (int'(idx) < QUBIT_NUM) m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/qpu_meas_tmo_cnt.sv
// -----------------------------------------------------------------------------
// qpu_meas_tmo_cnt
// Clearable, enabled up-counter with a terminal-count flag. Used by the
// collector to bound how long it waits for readout results.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset
//   clr_i - synchronous clear to zero (wins over en_i)
//   en_i  - count enable
//   tc_o  - high while the count equals TERMINAL
// -----------------------------------------------------------------------------
module qpu_meas_tmo_cnt #(
  parameter int          CNT_W    = 16,
  parameter int unsigned TERMINAL = 999
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TERMINAL);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i)  cnt_q <= cnt_q + 1'b1;
  end

  assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/qpu_meas_collect.sv
// -----------------------------------------------------------------------------
// qpu_meas_collect
// Collects out-of-order per-qubit readout results for one outstanding
// measurement instruction, then issues a single one-cycle write strobe with
// the assembled result bitmap and the mask of qubits actually received.
//
// Build option: define QPU_MEAS_TIMEOUT_EN to bound the collection phase to
// TMO_CYCLES cycles (forced commit with err_tmo). Without it the collector
// waits indefinitely and err_tmo is tied low.
//
// Ports:
//   clk, rst                   - clock / asynchronous active-high reset
//   start_valid/list/ready     - measurement dispatch handshake
//   rd_valid/qidx/bit/ready    - serial readout results
//   meas_wen/data/list         - registered commit to the register file
//   busy                       - collector not idle
//   err_unexp                  - pulse: a readout result was dropped
//   err_tmo                    - pulse with meas_wen on a timeout commit
// -----------------------------------------------------------------------------
module qpu_meas_collect
  import qpu_meas_collect_pkg::*;
#(
  parameter int TMO_W      = 16,
  parameter int TMO_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_valid,
  input  logic [QUBIT_NUM-1:0] start_list,
  output logic                 start_ready,
  input  logic                 rd_valid,
  input  logic [QIDX_W-1:0]    rd_qidx,
  input  logic                 rd_bit,
  output logic                 rd_ready,
  output logic                 meas_wen,
  output logic [QUBIT_NUM-1:0] meas_data,
  output logic [QUBIT_NUM-1:0] meas_list,
  output logic                 busy,
  output logic                 err_unexp,
  output logic                 err_tmo
);

  if (TMO_CYCLES < 1 || TMO_CYCLES > (2**TMO_W) - 1) begin : g_bad_tmo_cfg
    $error("qpu_meas_collect: TMO_CYCLES out of range for TMO_W");
  end

  meas_state_e state_q, state_d;
  qmask_t      pending_q, pending_d;
  qmask_t      data_q, data_d;
  qmask_t      recv_q, recv_d;

  logic   meas_wen_q, meas_wen_d;
  qmask_t meas_data_q, meas_data_d;
  qmask_t meas_list_q, meas_list_d;
  logic   err_unexp_q, err_unexp_d;
  logic   err_tmo_q, err_tmo_d;

  qmask_t rd_mask;
  logic   start_take;
  logic   rd_hit;
  logic   tmo_tc;
  logic   tmo_commit;

  assign rd_mask    = qidx_onehot(rd_qidx);
  assign start_take = (state_q == ST_IDLE) && start_valid && (start_list != '0);
  assign rd_hit     = (state_q == ST_COLLECT) && rd_valid && ((rd_mask & pending_q) != '0);

`ifdef QPU_MEAS_TIMEOUT_EN
  qpu_meas_tmo_cnt #(
    .CNT_W    (TMO_W),
    .TERMINAL (TMO_CYCLES - 1)
  ) u_tmo_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (start_take),
    .en_i  (state_q == ST_COLLECT),
    .tc_o  (tmo_tc)
  );
`else
  assign tmo_tc = 1'b0;
`endif

  // Completion takes priority: a timeout only counts if qubits are still
  // outstanding after this cycle's result has been absorbed.
  assign tmo_commit = (state_q == ST_COLLECT) && tmo_tc && (pending_d != '0);

  // ---------------------------------------------------------------- datapath
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    pending_d = pending_q;
    data_d    = data_q;
    recv_d    = recv_q;
    if (start_take) begin
      pending_d = start_list;
      data_d    = '0;
      recv_d    = '0;
    end else if (rd_hit) begin
      pending_d = pending_q & ~rd_mask;
      recv_d    = recv_q | rd_mask;
      data_d    = rd_bit ? (data_q | rd_mask) : (data_q & ~rd_mask);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      data_q    <= '0;
      recv_q    <= '0;
    end else begin
      pending_q <= pending_d;
      data_q    <= data_d;
      recv_q    <= recv_d;
    end
  end

  // ---------------------------------------------------------- state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // -------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (start_take) state_d = ST_COLLECT;
      ST_COLLECT: if (pending_d == '0 || tmo_tc) state_d = ST_COMMIT;
      ST_COMMIT:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // ----------------------------------------------------------------- outputs
  assign start_ready = (state_q == ST_IDLE);
  assign rd_ready    = (state_q == ST_COLLECT);
  assign busy        = (state_q != ST_IDLE);

  // Commit outputs are computed one cycle ahead and registered, so they are
  // glitch-free and held at zero outside COMMIT.
  always_comb begin
    meas_wen_d  = (state_d == ST_COMMIT);
    meas_data_d = meas_wen_d ? data_d : '0;
    meas_list_d = meas_wen_d ? recv_d : '0;
    err_tmo_d   = tmo_commit;
    err_unexp_d = rd_valid && !rd_hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meas_wen_q  <= 1'b0;
      meas_data_q <= '0;
      meas_list_q <= '0;
      err_unexp_q <= 1'b0;
      err_tmo_q   <= 1'b0;
    end else begin
      meas_wen_q  <= meas_wen_d;
      meas_data_q <= meas_data_d;
      meas_list_q <= meas_list_d;
      err_unexp_q <= err_unexp_d;
      err_tmo_q   <= err_tmo_d;
    end
  end

  assign meas_wen  = meas_wen_q;
  assign meas_data = meas_data_q;
  assign meas_list = meas_list_q;
  assign err_unexp = err_unexp_q;
  assign err_tmo   = err_tmo_q;

endmodule

// File: tb/tb_qpu_meas_collect.sv
// -----------------------------------------------------------------------------
// tb_qpu_meas_collect
// Directed scenarios followed by randomized traffic, each cycle compared
// against a transaction-level reference model of the collector. Works with
// and without QPU_MEAS_TIMEOUT_EN (timeout scenarios only in the former).
// -----------------------------------------------------------------------------
module tb_qpu_meas_collect;

  localparam int NQ  = 12;
  localparam int TMO = 8;
`ifdef QPU_MEAS_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_valid = 1'b0;
  logic [11:0] start_list = '0;
  logic        start_ready;
  logic        rd_valid = 1'b0;
  logic [3:0]  rd_qidx = '0;
  logic        rd_bit = 1'b0;
  logic        rd_ready;
  logic        meas_wen;
  logic [11:0] meas_data;
  logic [11:0] meas_list;
  logic        busy;
  logic        err_unexp;
  logic        err_tmo;

  always #5 clk = ~clk;

  qpu_meas_collect #(
    .TMO_W      (16),
    .TMO_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_list  (start_list),
    .start_ready (start_ready),
    .rd_valid    (rd_valid),
    .rd_qidx     (rd_qidx),
    .rd_bit      (rd_bit),
    .rd_ready    (rd_ready),
    .meas_wen    (meas_wen),
    .meas_data   (meas_data),
    .meas_list   (meas_list),
    .busy        (busy),
    .err_unexp   (err_unexp),
    .err_tmo     (err_tmo)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ------------------------------------------------------- reference model
  // A measurement is a set of wanted qubits; results tick them off. The
  // model tracks whether a measurement is open, how many COLLECT cycles it
  // has lasted, and whether the commit cycle is the current one.
  bit want[NQ];
  bit got_it[NQ];
  bit value[NQ];
  bit in_txn;
  bit committing;
  int age;
  bit          x_unexp, x_tmo;
  logic [11:0] x_data, x_list;

  function automatic int outstanding();
    int n = 0;
    for (int i = 0; i < NQ; i++) if (want[i]) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NQ; i++) begin want[i] = 0; got_it[i] = 0; value[i] = 0; end
    in_txn = 0; committing = 0; age = 0;
    x_unexp = 0; x_tmo = 0; x_data = '0; x_list = '0;
  endtask

  task automatic model_edge(input bit sv, input logic [11:0] sl,
                            input bit rv, input logic [3:0] rq, input bit rb);
    x_unexp = 0; x_tmo = 0; x_data = '0; x_list = '0;
    if (committing) begin
      committing = 0;
      if (rv) x_unexp = 1;
    end else if (in_txn) begin
      int q = int'(rq);
      if (rv && q < NQ && want[q]) begin
        want[q] = 0; got_it[q] = 1; value[q] = rb;
      end else if (rv) begin
        x_unexp = 1;
      end
      age++;
      if (outstanding() == 0 || (TMO_ON && age == TMO)) begin
        x_tmo = (outstanding() != 0);
        in_txn = 0;
        committing = 1;
        for (int i = 0; i < NQ; i++) begin
          x_data[i] = got_it[i] & value[i];
          x_list[i] = got_it[i];
        end
      end
    end else begin
      if (rv) x_unexp = 1;
      if (sv && sl != 0) begin
        in_txn = 1; age = 0;
        for (int i = 0; i < NQ; i++) begin
          want[i] = sl[i]; got_it[i] = 0; value[i] = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("start_ready", start_ready, !(in_txn || committing));
    check("busy",        busy,        in_txn || committing);
    check("rd_ready",    rd_ready,    in_txn);
    check("meas_wen",    meas_wen,    committing);
    check("meas_data",   meas_data,   x_data);
    check("meas_list",   meas_list,   x_list);
    check("err_tmo",     err_tmo,     x_tmo);
    check("err_unexp",   err_unexp,   x_unexp);
  endtask

  // One clock: drive at negedge, model at posedge, compare at next negedge.
  task automatic step(input bit sv, input logic [11:0] sl,
                      input bit rv, input logic [3:0] rq, input bit rb);
    start_valid = sv; start_list = sl;
    rd_valid = rv; rd_qidx = rq; rd_bit = rb;
    @(posedge clk);
    model_edge(sv, sl, rv, rq, rb);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_step();
    step(0, 12'h000, 0, 4'd0, 0);
  endtask

  task automatic reset_now();
    start_valid = 0; rd_valid = 0;
    rst = 1'b1;
    #1;
    check("rst_busy",  busy, 0);
    check("rst_ready", start_ready, 1);
    check("rst_wen",   meas_wen, 0);
    model_reset();
    @(negedge clk);
    check("rst_hold_wen", meas_wen, 0);
    rst = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst = 1'b0;
    idle_step();

    // Normal commit, results out of order.
    step(1, 12'h005, 0, 4'd0, 0);
    step(0, 12'h000, 1, 4'd2, 1);
    step(0, 12'h000, 1, 4'd0, 0);
    check("norm_wen",  meas_wen, 1);
    check("norm_data", meas_data, 12'h004);
    check("norm_list", meas_list, 12'h005);
    check("norm_tmo",  err_tmo, 0);
    idle_step();
    check("norm_ready", start_ready, 1);

    // Unexpected result while collecting.
    step(1, 12'h001, 0, 4'd0, 0);
    step(0, 12'h000, 1, 4'd3, 1);
    check("unexp_pulse", err_unexp, 1);
    step(0, 12'h000, 1, 4'd0, 1);
    check("unexp_wen",  meas_wen, 1);
    check("unexp_data", meas_data, 12'h001);
    check("unexp_list", meas_list, 12'h001);
    idle_step();

`ifdef QPU_MEAS_TIMEOUT_EN
    // Timeout: only one of two qubits reports.
    step(1, 12'h003, 0, 4'd0, 0);
    step(0, 12'h000, 1, 4'd1, 1);
    n = 1;
    while (!meas_wen && n < 20) begin
      idle_step();
      n++;
    end
    check("tmo_latency", n, TMO);
    check("tmo_data", meas_data, 12'h002);
    check("tmo_list", meas_list, 12'h002);
    check("tmo_flag", err_tmo, 1);
    idle_step();

    // Last result lands in the timeout cycle: normal commit.
    step(1, 12'h003, 0, 4'd0, 0);
    step(0, 12'h000, 1, 4'd0, 1);
    repeat (TMO - 2) idle_step();
    step(0, 12'h000, 1, 4'd1, 0);
    check("sim_wen",  meas_wen, 1);
    check("sim_tmo",  err_tmo, 0);
    check("sim_data", meas_data, 12'h001);
    check("sim_list", meas_list, 12'h003);
    idle_step();
`else
    n = 0;
`endif

    // Reset mid-COLLECT discards the partial result.
    step(1, 12'h003, 0, 4'd0, 0);
    step(0, 12'h000, 1, 4'd0, 1);
    reset_now();
    idle_step();
    step(1, 12'h800, 0, 4'd0, 0);
    step(0, 12'h000, 1, 4'd11, 1);
    check("post_rst_wen",  meas_wen, 1);
    check("post_rst_data", meas_data, 12'h800);
    idle_step();

    // Illegal inputs: start while busy, out-of-range index, zero list.
    step(1, 12'h001, 0, 4'd0, 0);
    check("busy_no_ready", start_ready, 0);
    step(1, 12'h002, 0, 4'd0, 0);
    step(0, 12'h000, 1, 4'd13, 1);
    check("oor_unexp", err_unexp, 1);
    step(0, 12'h000, 1, 4'd0, 0);
    check("ill_list", meas_list, 12'h001);
    check("ill_data", meas_data, 12'h000);
    idle_step();
    step(1, 12'h000, 0, 4'd0, 0);
    check("zero_busy", busy, 0);
    check("zero_wen",  meas_wen, 0);

    // Randomized traffic.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit          sv, rv, rb;
      logic [11:0] sl;
      logic [3:0]  rq;
      sv = 0; sl = '0; rv = 0; rq = '0; rb = 1'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        reset_now();
        continue;
      end
      if (in_txn) begin
        if ($urandom_range(0, 9) < 6) begin
          int cand[$];
          rv = 1;
          for (int i = 0; i < NQ; i++) if (want[i]) cand.push_back(i);
          if ($urandom_range(0, 4) != 0 && cand.size() > 0)
            rq = 4'(cand[$urandom_range(0, cand.size() - 1)]);
          else
            rq = 4'($urandom_range(0, 15));
        end
        if ($urandom_range(0, 7) == 0) begin sv = 1; sl = 12'($urandom); end
      end else begin
        if ($urandom_range(0, 7) < 4) begin
          sv = 1;
          case ($urandom_range(0, 3))
            0:       sl = '0;
            1:       sl = 12'($urandom) & 12'h00F;
            default: sl = 12'($urandom);
          endcase
        end
        if ($urandom_range(0, 7) == 0) begin rv = 1; rq = 4'($urandom_range(0, 15)); end
      end
      step(sv, sl, rv, rq, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
